// File: rtl/i2c_target_od.sv
// I2C target behind open-drain SCL/SDA pads, bridging one 7-bit address to a byte-wide
// register bus. Supports pointer write, burst write and burst read (with repeated start).
// SDA is only ever pulled low via sda_oe; there is no clock stretching.
//
// Ports:
//   clk        system clock, at least 20x SCL
//   resetn     synchronous reset, active low
//   scl_in     SCL pad input (asynchronous)
//   sda_in     SDA pad input (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   reg_addr   register pointer
//   reg_wdata  write data
//   reg_we     single-cycle write strobe
//   reg_re     single-cycle read strobe
//   reg_rdata  read data, valid the cycle after reg_re
//   busy       high from an addressed START until STOP
module i2c_target_od #(
  parameter logic [6:0]  I2C_ADDR    = 7'h42,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdAck, StIgnore
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning: synchronizer, then agreement filter
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic [FILTER_LEN-1:0]  scl_hist_q, sda_hist_q;
  logic                   scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= {scl_hist_q[FILTER_LEN-2:0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[FILTER_LEN-2:0], sda_sync_q[SYNC_STAGES-1]};
      // Filtered line only moves once the whole history agrees
      if (&scl_hist_q)       scl_f_q <= 1'b1;
      else if (~|scl_hist_q) scl_f_q <= 1'b0;
      if (&sda_hist_q)       sda_f_q <= 1'b1;
      else if (~|sda_hist_q) sda_f_q <= 1'b0;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_f_q & ~scl_prev_q;
  assign scl_fall = ~scl_f_q & scl_prev_q;
  // SCL must be high in both cycles so an SCL edge never looks like START/STOP
  assign start_ev = sda_prev_q & ~sda_f_q & scl_f_q & scl_prev_q;
  assign stop_ev  = ~sda_prev_q & sda_f_q & scl_f_q & scl_prev_q;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       re_req_q, re_req_d;   // issue reg_re next clk (after pointer increment)
  logic       rd_pend_q, rd_pend_d; // reg_rdata is valid this cycle, load it
  logic       busy_q, busy_d;
  logic [7:0] rx_byte;

  assign rx_byte = {sr_q[6:0], sda_f_q};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      re_req_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      re_req_q    <= re_req_d;
      rd_pend_q   <= rd_pend_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    re_req_d    = 1'b0;
    rd_pend_d   = reg_re_q;
    busy_d      = busy_q;

    if (start_ev) begin
      state_d   = StAddr;
      cnt_d     = '0;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
      rd_pend_d = 1'b0;
    end else if (stop_ev) begin
      state_d   = StIdle;
      cnt_d     = '0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      rd_pend_d = 1'b0;
    end else begin
      if (re_req_q) reg_re_d = 1'b1;

      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            sr_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            rw_d  = sr_q[0];
            if (sr_q[7:1] == I2C_ADDR) begin
              state_d  = StAddrAck;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = StIgnore;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            if (rw_q) begin
              reg_re_d = 1'b1;
              state_d  = StRdata;
            end else begin
              state_d  = StPtr;
            end
          end
        end
        StPtr: begin
          if (scl_rise) begin
            sr_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) reg_addr_d = rx_byte;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d    = '0;
            sda_oe_d = 1'b1;
            state_d  = StPtrAck;
          end
        end
        StPtrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StWdata;
          end
        end
        StWdata: begin
          if (scl_rise) begin
            sr_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              reg_wdata_d = rx_byte;
              reg_we_d    = 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d    = '0;
            sda_oe_d = 1'b1;
            state_d  = StWdataAck;
          end
        end
        StWdataAck: begin
          if (scl_fall) begin
            sda_oe_d   = 1'b0;
            reg_addr_d = reg_addr_q + 8'd1;
            state_d    = StWdata;
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = StRdAck;
            end else begin
              // sr_q[7] is already on the bus; present the next bit
              sda_oe_d = ~sr_q[6];
              sr_d     = {sr_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            nack_d = sda_f_q;
          end else if (scl_fall) begin
            if (nack_q) begin
              sda_oe_d = 1'b0;
              state_d  = StIgnore;
            end else begin
              reg_addr_d = reg_addr_q + 8'd1;
              re_req_d   = 1'b1;
              state_d    = StRdata;
            end
          end
        end
        default: ;
      endcase

      // Load the fetched byte and drive its MSB; counts as the first bit sent
      if (rd_pend_q && state_q == StRdata) begin
        sr_d     = reg_rdata;
        sda_oe_d = ~reg_rdata[7];
        cnt_d    = 4'd1;
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_od.sv
// Bench for i2c_target_od: an open-drain I2C master model plus a register-bus monitor.
// Write transactions come from a vector table; read, glitch, early STOP and reset
// cases are hand-written sequences.
module tb_i2c_target_od;

  localparam int T = 10; // clks per quarter SCL period

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  assign sda_bus   = sda_m & ~sda_oe;
  assign reg_rdata = reg_addr ^ 8'h3C;

  always #5 clk = ~clk;

  i2c_target_od #(
    .I2C_ADDR   (7'h42),
    .SYNC_STAGES(2),
    .FILTER_LEN (3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Register-bus monitor
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] ra[$];
  int         conflicts = 0;
  logic       oe_seen = 1'b0;

  always @(negedge clk) begin
    if (reg_we) begin
      wa.push_back(reg_addr);
      wd.push_back(reg_wdata);
    end
    if (reg_re) ra.push_back(reg_addr);
    if (reg_we && reg_re) conflicts++;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    ra.delete();
    oe_seen = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // START or repeated START; entered with SCL low (or bus idle), leaves SCL low
  task automatic i2c_start();
    sda_m = 1'b1; tick(T);
    scl_m = 1'b1; tick(T);
    sda_m = 1'b0; tick(T);
    scl_m = 1'b0; tick(T);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(T);
    scl_m = 1'b1; tick(T);
    sda_m = 1'b1; tick(T);
  endtask

  // glen > 0 inserts a low glitch of glen clks in the middle of the high phase
  task automatic write_bit(input logic b, input int glen);
    sda_m = b; tick(T);
    scl_m = 1'b1; tick(T);
    if (glen > 0) begin
      scl_m = 1'b0; tick(glen);
      scl_m = 1'b1;
    end
    tick(T);
    scl_m = 1'b0; tick(T);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(T);
    scl_m = 1'b1; tick(T);
    b = sda_bus; tick(T);
    scl_m = 1'b0; tick(T);
  endtask

  task automatic write_byte(input logic [7:0] d, input int gbit, input int glen,
                            output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i], (i == gbit) ? glen : 0);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack, 0);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] acks;
    logic       busy_mid;
    int         nw;
    logic [7:0] a0;
    logic [7:0] w0;
    logic [7:0] a1;
    logic [7:0] w1;
  } wr_vec_t;

  wr_vec_t vec[3];

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [3:0] acks;
    logic [2:0] racks;
    logic [7:0] d;

    vec[0] = '{8'h84, 8'h10, 8'hA5, 8'h5A, 4'b1111, 1'b1, 2, 8'h10, 8'hA5, 8'h11, 8'h5A};
    vec[1] = '{8'h86, 8'h10, 8'hA5, 8'h5A, 4'b0000, 1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[2] = '{8'h84, 8'hFF, 8'h11, 8'h22, 4'b1111, 1'b1, 2, 8'hFF, 8'h11, 8'h00, 8'h22};

    // Reset state
    resetn = 1'b0;
    tick(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_reg_re", reg_re, 1'b0);
    check("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    tick(2 * T);

    // Table-driven write transactions
    for (int v = 0; v < 3; v++) begin
      clear_log();
      i2c_start();
      write_byte(vec[v].dev, -1, 0, ack); acks[3] = ack;
      check($sformatf("v%0d_busy_mid", v), busy, vec[v].busy_mid);
      write_byte(vec[v].ptr, -1, 0, ack); acks[2] = ack;
      write_byte(vec[v].d0, -1, 0, ack);  acks[1] = ack;
      write_byte(vec[v].d1, -1, 0, ack);  acks[0] = ack;
      i2c_stop();
      tick(T);
      check($sformatf("v%0d_acks", v), acks, vec[v].acks);
      check($sformatf("v%0d_oe_seen", v), oe_seen, vec[v].acks[3]);
      check($sformatf("v%0d_nwrites", v), wa.size(), vec[v].nw);
      check($sformatf("v%0d_nreads", v), ra.size(), 0);
      if (vec[v].nw > 0 && wa.size() > 0) begin
        check($sformatf("v%0d_wa0", v), wa[0], vec[v].a0);
        check($sformatf("v%0d_wd0", v), wd[0], vec[v].w0);
      end
      if (vec[v].nw > 1 && wa.size() > 1) begin
        check($sformatf("v%0d_wa1", v), wa[1], vec[v].a1);
        check($sformatf("v%0d_wd1", v), wd[1], vec[v].w1);
      end
      check($sformatf("v%0d_busy_end", v), busy, 1'b0);
    end

    // Pointer write, repeated START, burst read with wrap
    clear_log();
    i2c_start();
    write_byte(8'h84, -1, 0, ack); acks[3] = ack;
    write_byte(8'hFE, -1, 0, ack); acks[2] = ack;
    i2c_start();
    write_byte(8'h85, -1, 0, ack); acks[1] = ack;
    check("rd_acks", acks[3:1], 3'b111);
    read_byte(d, 1'b0);
    check("rd_byte0", d, 8'hC2);
    read_byte(d, 1'b0);
    check("rd_byte1", d, 8'hC3);
    read_byte(d, 1'b1);
    check("rd_byte2", d, 8'h3C);
    check("rd_oe_after_nack", sda_oe, 1'b0);
    check("rd_busy_after_nack", busy, 1'b1);
    i2c_stop();
    tick(T);
    check("rd_busy_end", busy, 1'b0);
    check("rd_nreads", ra.size(), 3);
    if (ra.size() == 3) begin
      check("rd_ra0", ra[0], 8'hFE);
      check("rd_ra1", ra[1], 8'hFF);
      check("rd_ra2", ra[2], 8'h00);
    end
    check("rd_nwrites", wa.size(), 0);

    // SCL glitches: 1 clk in the pointer byte, 2 clks in the data byte
    clear_log();
    i2c_start();
    write_byte(8'h84, -1, 0, ack); racks[2] = ack;
    write_byte(8'h20, 3, 1, ack);  racks[1] = ack;
    write_byte(8'h3C, 5, 2, ack);  racks[0] = ack;
    i2c_stop();
    tick(T);
    check("gl_acks", racks, 3'b111);
    check("gl_nwrites", wa.size(), 1);
    if (wa.size() > 0) begin
      check("gl_wa", wa[0], 8'h20);
      check("gl_wd", wd[0], 8'h3C);
    end

    // STOP after 4 bits of a data byte, then a normal transaction
    clear_log();
    i2c_start();
    write_byte(8'h84, -1, 0, ack);
    write_byte(8'h30, -1, 0, ack);
    write_bit(1'b1, 0);
    write_bit(1'b0, 0);
    write_bit(1'b1, 0);
    write_bit(1'b1, 0);
    i2c_stop();
    tick(T);
    check("es_nwrites", wa.size(), 0);
    check("es_sda_oe", sda_oe, 1'b0);
    check("es_busy", busy, 1'b0);
    check("es_reg_addr", reg_addr, 8'h30);
    clear_log();
    i2c_start();
    write_byte(8'h84, -1, 0, ack); racks[2] = ack;
    write_byte(8'h31, -1, 0, ack); racks[1] = ack;
    write_byte(8'h77, -1, 0, ack); racks[0] = ack;
    i2c_stop();
    tick(T);
    check("es2_acks", racks, 3'b111);
    check("es2_nwrites", wa.size(), 1);
    if (wa.size() > 0) begin
      check("es2_wa", wa[0], 8'h31);
      check("es2_wd", wd[0], 8'h77);
    end
    check("es2_reg_addr", reg_addr, 8'h32);

    // Reset while the target is driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(((8'h84 >> i) & 8'h01) != 0, 0);
    sda_m = 1'b1;
    tick(T);
    check("mr_oe_before", sda_oe, 1'b1);
    resetn = 1'b0;
    tick(1);
    check("mr_sda_oe", sda_oe, 1'b0);
    check("mr_reg_addr", reg_addr, 8'h00);
    check("mr_busy", busy, 1'b0);
    resetn = 1'b1;
    tick(2 * T);
    i2c_stop();
    tick(T);
    check("mr_busy_end", busy, 1'b0);

    check("we_re_exclusive", conflicts, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
